// File: rtl/shift_add_multiplier_pkg.sv
// rtl/shift_add_multiplier_pkg.sv - shared constants and state type for the shift-add multiplier
//
// Purpose: operand width, iteration counter width and FSM state encoding
//          used by shift_add_multiplier and its adder.
// Ports:   none (package).
package shift_add_multiplier_pkg;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_carry_adder_rtl.sv
// rtl/ripple_carry_adder_rtl.sv - 4-bit ripple carry adder
//
// Purpose: combinational InputA + InputB + InputCarry through a chain of
//          full adders.
// Ports:
//   InputA, InputB  in   4  addends
//   InputCarry      in   1  carry into bit 0
//   SumOut          out  4  sum bits
//   CarryOut        out  1  carry out of the MSB
module ripple_carry_adder_rtl (
  input  logic [shift_add_multiplier_pkg::WIDTH-1:0] InputA,
  input  logic [shift_add_multiplier_pkg::WIDTH-1:0] InputB,
  input  logic                                       InputCarry,
  output logic [shift_add_multiplier_pkg::WIDTH-1:0] SumOut,
  output logic                                       CarryOut
);

  localparam int W = shift_add_multiplier_pkg::WIDTH;

  logic [W:0] carry;

  assign carry[0] = InputCarry;

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_fa
      assign SumOut[i]    = InputA[i] ^ InputB[i] ^ carry[i];
      assign carry[i + 1] = (InputA[i] & InputB[i]) | (carry[i] & (InputA[i] ^ InputB[i]));
    end
  endgenerate

  assign CarryOut = carry[W];

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential 4x4 unsigned shift-and-add multiplier
//
// Purpose: accepts an operand pair, performs one conditional add + right
//          shift per cycle for 4 cycles, then holds the 8-bit product until
//          the consumer takes it.
// Optional feature: define MULT_ZERO_SKIP_EN to finish after a single RUN
//          cycle when either operand is zero.
// Ports:
//   Clock       in   1  rising-edge clock
//   ResetN      in   1  asynchronous active-low reset
//   InValid     in   1  operand pair valid
//   InReady     out  1  operands accepted (IDLE only)
//   InputA      in   4  multiplicand
//   InputB      in   4  multiplier
//   OutValid    out  1  product valid, held until OutReady
//   OutReady    in   1  consumer accepts product
//   ProductOut  out  8  InputA * InputB
module shift_add_multiplier
  import shift_add_multiplier_pkg::state_t,
         shift_add_multiplier_pkg::IDLE,
         shift_add_multiplier_pkg::RUN,
         shift_add_multiplier_pkg::DONE,
         shift_add_multiplier_pkg::CNT_W;
#(
  parameter int WIDTH = shift_add_multiplier_pkg::WIDTH
) (
  input  logic               Clock,
  input  logic               ResetN,
  input  logic               InValid,
  output logic               InReady,
  input  logic [WIDTH-1:0]   InputA,
  input  logic [WIDTH-1:0]   InputB,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [2*WIDTH-1:0] ProductOut
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state_q, state_next;

  logic [WIDTH-1:0]   a_q;        // latched multiplicand
  logic [2*WIDTH-1:0] p_q;        // {Hi, Lo}; C is always 0 after a shift so it is not stored
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]   sum;
  logic               carry_out;
  logic [WIDTH:0]     acc;        // {C, Hi} after the conditional add
  logic [2*WIDTH-1:0] p_next;     // {C, Hi, Lo} >> 1, top (always-zero) bit dropped
  logic               skip;
  logic               run_last;

  ripple_carry_adder_rtl u_adder (
    .InputA     (p_q[2*WIDTH-1:WIDTH]),
    .InputB     (a_q),
    .InputCarry (1'b0),
    .SumOut     (sum),
    .CarryOut   (carry_out)
  );

`ifdef MULT_ZERO_SKIP_EN
  logic zero_q;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      zero_q <= 1'b0;
    end else if (state_q == IDLE && InValid) begin
      zero_q <= (InputA == '0) || (InputB == '0);
    end
  end

  assign skip = zero_q;
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    acc      = p_q[0] ? {carry_out, sum} : {1'b0, p_q[2*WIDTH-1:WIDTH]};
    p_next   = {acc, p_q[WIDTH-1:1]};
    run_last = skip || (cnt_q == CNT_LAST);
  end

  // FSM state register
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // FSM next state
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (InValid)  state_next = RUN;
      RUN:     if (run_last) state_next = DONE;
      DONE:    if (OutReady) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, product latch on DONE entry
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      a_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (InValid) begin
            a_q   <= InputA;
            p_q   <= {{WIDTH{1'b0}}, InputB};
            cnt_q <= '0;
          end
        end
        RUN: begin
          p_q   <= p_next;
          cnt_q <= cnt_q + 1'b1;
          if (run_last) begin
            product_q <= skip ? '0 : p_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign InReady    = (state_q == IDLE);
  assign OutValid   = (state_q == DONE);
  assign ProductOut = product_q;

endmodule
